subneg_ctrl: RTL and testbench
==============================

# subneg_ctrl

Sequencing controller for the SUBNEG one-instruction processor. It fetches the three instruction words (A, B, C) from the program ROM and reads the operands mem[A] and mem[B] from data memory. It then writes mem[B] − mem[A] back to mem[B] and steers the PC register to either PC+3 or the branch target C. It drives every enable of the pc/op1/op2 registers, the PC mux and both memories; the subtractor, incrementer and mux stay purely datapath.

## Interface
- WIDTH, 8, data word, ROM/data address and PC width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution at current pc (IDLE only)
- stop  in  1  one-cycle pulse; stop after the instruction in flight completes
- pc  in  WIDTH  current PC register value
- rom_rd  out  1  ROM read strobe
- rom_addr  out  WIDTH  ROM read address
- rom_q  in  WIDTH  ROM data, valid the cycle after rom_rd
- dmem_rd  out  1  data memory read strobe
- dmem_we  out  1  data memory write enable; write data is the subtractor output
- dmem_addr  out  WIDTH  data memory address
- dmem_q  in  WIDTH  data memory read data, valid the cycle after dmem_rd
- op1_ld  out  1  load op1 register from dmem_q
- op2_ld  out  1  load op2 register from dmem_q
- neg  in  1  subtractor result MSB (op2 − op1 < 0)
- pc_ld  out  1  load PC register from mux
- pc_sel  out  1  mux select: 0 = incrementer (pc+3), 1 = br_target
- br_target  out  WIDTH  latched C field
- busy  out  1  high in any state other than IDLE/HALT
- halted  out  1  high in HALT

## Operation
- States: IDLE, FA, FB, FC, RA, RB, EX, WB, HALT.
- The controller holds internal registers a_q, b_q, c_q (WIDTH each) and stop_pend (1 bit).
- IDLE: all strobes low. start → FA.
- FA: rom_rd=1, rom_addr=pc. Next state FB.
- FB: a_q←rom_q; rom_rd=1, rom_addr=pc+1. Next state FC.
- FC: b_q←rom_q; rom_rd=1, rom_addr=pc+2. Next state RA.
- RA: c_q←rom_q; dmem_rd=1, dmem_addr=a_q. Next state RB.
- RB: op1_ld=1 (op1←mem[A]); dmem_rd=1, dmem_addr=b_q. Next state EX.
- EX: op2_ld=1 (op2←mem[B]). Next state WB.
- WB: the subtractor output op2−op1 is stable.
  - dmem_we=1, dmem_addr=b_q; pc_ld=1, pc_sel=neg.
  - If neg=1 and c_q==pc, go to HALT (self-branch halt).
  - Otherwise, if stop_pend=1 or stop=1, go to IDLE.
  - Otherwise go to FA.
- HALT: all strobes low, halted=1. Only reset exits HALT; start is ignored.
- Arithmetic: pc+1 and pc+2 wrap modulo 2^WIDTH. A result of zero is not negative, so there is no branch on zero.
- stop:
  - A stop pulse in FA..EX sets stop_pend.
  - stop_pend clears on entry to IDLE.
  - stop in IDLE or HALT is ignored.
  - If start and stop arrive together in IDLE, start takes effect and stop is discarded.
- start while busy or halted: ignored.
- br_target=c_q at all times; pc_sel is low outside WB.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE;
  - a_q, b_q, c_q = 0; stop_pend = 0;
  - all outputs 0 (rom_addr, dmem_addr and br_target included).
- Release of reset is synchronous to clk.
- All outputs are Moore, decoded from state and registers. The exception is pc_sel, which combinationally follows neg in WB.
- Latency:
  - 7 cycles per instruction (FA→WB). The next FA follows WB immediately.
  - The first rom_rd comes 1 cycle after the start pulse.
- Memory reads: data returned on the cycle after the strobe is captured in that next state. No wait states.
- The PC update and the memory write take effect on the same rising edge that leaves WB. The next FA therefore sees the new pc.
- Reset asserted mid-instruction aborts immediately:
  - no write is committed;
  - the PC register is not loaded by this block;
  - the datapath PC register has its own reset.

## Test plan
- **Reset/idle:** hold rst=0, then release with no start → all outputs 0, state stays IDLE, busy=0 for 10 cycles.
- **Non-branching instruction:** ROM[0..2]={10,11,20}, mem[10]=3, mem[11]=5, start at pc=0.
  - Expected: rom_addr 0,1,2 on cycles 1–3; dmem reads 10 then 11; WB writes 2 to addr 11 with pc_sel=0.
  - Next FA at rom_addr=3, 8 cycles after start.
- **Branching instruction:** mem[10]=7, mem[11]=5, C=20.
  - Expected: writes 0xFE to addr 11, neg=1, pc_sel=1, br_target=20; next FA has rom_addr=20.
- **Zero result:** mem[10]=mem[11]=4 → writes 0, pc_sel=0, no branch.
- **Self-branch halt:** instruction at pc=6 with C=6 and a negative result → halted=1, busy=0; a later start pulse is ignored; only rst=0 returns to IDLE.
- **Stop and wrap-around:**
  - stop pulsed during RB → current WB completes, then IDLE; stop_pend is cleared, and a new start runs normally.
  - pc=0xFE → rom_addr sequence is 0xFE, 0xFF, 0x00.

Source files
------------

// File: rtl/subneg_if.sv
// rtl/subneg_if.sv - Controller to datapath/memory signal bundle for the SUBNEG sequencer
interface subneg_if #(parameter int WIDTH = 8);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] pc;
    logic             rom_rd;
    logic [WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_q;
    logic             dmem_rd;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_q;
    logic             op1_ld;
    logic             op2_ld;
    logic             neg;
    logic             pc_ld;
    logic             pc_sel;
    logic [WIDTH-1:0] br_target;
    logic             busy;
    logic             halted;

    modport master (
        input  start, stop, pc, rom_q, dmem_q, neg,
        output rom_rd, rom_addr, dmem_rd, dmem_we, dmem_addr,
               op1_ld, op2_ld, pc_ld, pc_sel, br_target, busy, halted
    );

    modport slave (
        output start, stop, pc, rom_q, dmem_q, neg,
        input  rom_rd, rom_addr, dmem_rd, dmem_we, dmem_addr,
               op1_ld, op2_ld, pc_ld, pc_sel, br_target, busy, halted
    );
endinterface

// File: rtl/subneg_ctrl.sv
// rtl/subneg_ctrl.sv - Fetch/read/execute/writeback sequencer for the SUBNEG one-instruction CPU
module subneg_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    subneg_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_EX, S_WB, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic             stop_pend_q, stop_pend_d;
    logic             rom_rd_q, rom_rd_d;
    logic [1:0]       rom_off_q, rom_off_d;
    logic             dmem_rd_q, dmem_rd_d;
    logic             dmem_we_q, dmem_we_d;
    logic [WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic             op1_ld_q, op1_ld_d;
    logic             op2_ld_q, op2_ld_d;
    logic             pc_ld_q, pc_ld_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             self_branch;

    // A taken branch back onto its own address can never make progress.
    assign self_branch = bus.neg && (c_q == bus.pc);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE: if (bus.start) state_d = S_FA;
            S_FA:   state_d = S_FB;
            S_FB: begin
                a_d     = bus.rom_q;
                state_d = S_FC;
            end
            S_FC: begin
                b_d     = bus.rom_q;
                state_d = S_RA;
            end
            S_RA: begin
                c_d     = bus.rom_q;
                state_d = S_RB;
            end
            S_RB:   state_d = S_EX;
            S_EX:   state_d = S_WB;
            S_WB: begin
                if (self_branch)                   state_d = S_HALT;
                else if (stop_pend_q || bus.stop)  state_d = S_IDLE;
                else                               state_d = S_FA;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (bus.stop && (state_q inside {S_FA, S_FB, S_FC, S_RA, S_RB, S_EX}))
            stop_pend_d = 1'b1;
        if (state_d == S_IDLE)
            stop_pend_d = 1'b0;

        // Outputs are decoded from the next state so they leave the flops clean.
        rom_rd_d  = state_d inside {S_FA, S_FB, S_FC};
        dmem_rd_d = state_d inside {S_RA, S_RB};
        dmem_we_d = (state_d == S_WB);
        op1_ld_d  = (state_d == S_RB);
        op2_ld_d  = (state_d == S_EX);
        pc_ld_d   = (state_d == S_WB);
        busy_d    = !(state_d inside {S_IDLE, S_HALT});
        halted_d  = (state_d == S_HALT);

        case (state_d)
            S_FB:    rom_off_d = 2'd1;
            S_FC:    rom_off_d = 2'd2;
            default: rom_off_d = 2'd0;
        endcase

        case (state_d)
            S_RA:       dmem_addr_d = a_d;
            S_RB, S_WB: dmem_addr_d = b_d;
            default:    dmem_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            stop_pend_q <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_off_q   <= 2'd0;
            dmem_rd_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            op1_ld_q    <= 1'b0;
            op2_ld_q    <= 1'b0;
            pc_ld_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            stop_pend_q <= stop_pend_d;
            rom_rd_q    <= rom_rd_d;
            rom_off_q   <= rom_off_d;
            dmem_rd_q   <= dmem_rd_d;
            dmem_we_q   <= dmem_we_d;
            dmem_addr_q <= dmem_addr_d;
            op1_ld_q    <= op1_ld_d;
            op2_ld_q    <= op2_ld_d;
            pc_ld_q     <= pc_ld_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    // The PC changes on the edge that enters FA, so the fetch address tracks it live.
    assign bus.rom_addr  = rom_rd_q ? (bus.pc + WIDTH'(rom_off_q)) : '0;
    assign bus.rom_rd    = rom_rd_q;
    assign bus.dmem_rd   = dmem_rd_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.dmem_addr = dmem_addr_q;
    assign bus.op1_ld    = op1_ld_q;
    assign bus.op2_ld    = op2_ld_q;
    assign bus.pc_ld     = pc_ld_q;
    assign bus.pc_sel    = pc_ld_q & bus.neg;
    assign bus.br_target = c_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_subneg_ctrl.sv
// tb/tb_subneg_ctrl.sv - Self-checking bench for subneg_ctrl against an instruction-level model
module tb_subneg_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    subneg_if #(.WIDTH(W)) bus ();
    subneg_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] rom [256];
    logic [7:0] dp_mem [256] = '{default: 8'd0};
    logic [7:0] ref_mem [256] = '{default: 8'd0};
    logic [7:0] dp_pc = 8'd0, op1 = 8'd0, op2 = 8'd0, rom_q_r = 8'd0, dmem_q_r = 8'd0;
    logic [7:0] diff;
    logic       ld_en = 1'b0, ld_kind = 1'b0;
    logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath and memories the controller steers.
    assign diff        = op2 - op1;
    assign bus.pc      = dp_pc;
    assign bus.rom_q   = rom_q_r;
    assign bus.dmem_q  = dmem_q_r;
    assign bus.neg     = diff[7];

    always @(posedge clk) begin
        if (bus.rom_rd)  rom_q_r <= rom[bus.rom_addr];
        if (bus.dmem_rd) dmem_q_r <= dp_mem[bus.dmem_addr];
        if (bus.op1_ld)  op1 <= dmem_q_r;
        if (bus.op2_ld)  op2 <= dmem_q_r;
        if (bus.dmem_we) dp_mem[bus.dmem_addr] <= diff;
        if (bus.pc_ld)   dp_pc <= bus.pc_sel ? bus.br_target : dp_pc + 8'd3;
        if (ld_en) begin
            if (ld_kind) dp_pc <= ld_data;
            else         dp_mem[ld_addr] <= ld_data;
        end
    end

    // Instruction-level reference: mode 0 idle, 1 running, 2 halted; m_k = cycle within instruction.
    int         m_mode = 0;
    int         m_k = 0;
    logic       m_sp = 1'b0;
    logic [7:0] m_pc = 8'd0, m_brt = 8'd0;
    logic [7:0] fa, fb, fc, r, e_ra, e_da;
    logic       e_rd, e_dr, e_we, e_l1, e_l2, e_pl, e_ps;
    logic [32:0] e_vec, a_vec;

    always @(negedge clk) begin
        if (!rst) begin
            m_mode = 0; m_k = 0; m_sp = 1'b0; m_brt = 8'd0;
        end
        fa = rom[m_pc];
        fb = rom[8'(m_pc + 8'd1)];
        fc = rom[8'(m_pc + 8'd2)];
        r  = ref_mem[fb] - ref_mem[fa];
        e_rd = 0; e_ra = 0; e_dr = 0; e_we = 0; e_da = 0;
        e_l1 = 0; e_l2 = 0; e_pl = 0; e_ps = 0;
        if (m_mode == 1) begin
            case (m_k)
                0: begin e_rd = 1; e_ra = m_pc; end
                1: begin e_rd = 1; e_ra = m_pc + 8'd1; end
                2: begin e_rd = 1; e_ra = m_pc + 8'd2; end
                3: begin e_dr = 1; e_da = fa; end
                4: begin e_dr = 1; e_da = fb; e_l1 = 1; end
                5: e_l2 = 1;
                6: begin e_we = 1; e_da = fb; e_pl = 1; e_ps = r[7]; end
                default: ;
            endcase
        end
        e_vec = {e_rd, e_ra, e_dr, e_we, e_da, e_l1, e_l2, e_pl, e_ps, m_brt,
                 m_mode == 1, m_mode == 2};
        a_vec = {bus.rom_rd, bus.rom_addr, bus.dmem_rd, bus.dmem_we, bus.dmem_addr,
                 bus.op1_ld, bus.op2_ld, bus.pc_ld, bus.pc_sel, bus.br_target,
                 bus.busy, bus.halted};
        chk("outputs", a_vec, e_vec);
        chk("pc_reg", dp_pc, m_pc);
        if (m_mode == 1 && m_k == 6) chk("wb_data", diff, r);

        if (rst) begin
            if (ld_en) begin
                if (ld_kind) m_pc = ld_data;
                else         ref_mem[ld_addr] = ld_data;
            end
            case (m_mode)
                0: if (bus.start) begin m_mode = 1; m_k = 0; end
                1: begin
                    if (bus.stop && m_k <= 5) m_sp = 1'b1;
                    if (m_k == 3) m_brt = fc;
                    if (m_k == 6) begin
                        ref_mem[fb] = r;
                        if (r[7] && fc == m_pc) m_mode = 2;
                        else if (m_sp || bus.stop) begin m_mode = 0; m_sp = 1'b0; end
                        m_k  = 0;
                        m_pc = r[7] ? fc : m_pc + 8'd3;
                    end else begin
                        m_k++;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic poke(input logic kind, input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_kind = kind; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("idle_quiet", {bus.busy, bus.rom_rd, bus.dmem_rd, bus.halted, bus.rom_addr}, 12'h000);
        end

        // Non-branching instruction, then a stopped one.
        rom[0] = 8'd10; rom[1] = 8'd11; rom[2] = 8'd20;
        rom[3] = 8'd12; rom[4] = 8'd13; rom[5] = 8'd30;
        rom[6] = 8'd14; rom[7] = 8'd15; rom[8] = 8'd6;
        poke(0, 10, 3); poke(0, 11, 5); poke(0, 12, 1); poke(0, 13, 9);
        poke(0, 14, 9); poke(0, 15, 2); poke(1, 0, 0);
        pulse_start();
        chk("t1_fa", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'd0});
        step(1); chk("t1_fb", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'd1});
        step(1); chk("t1_fc", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'd2});
        step(1); chk("t1_ra", {bus.dmem_rd, bus.dmem_addr}, {1'b1, 8'd10});
        step(1); chk("t1_rb", {bus.dmem_rd, bus.dmem_addr, bus.op1_ld}, {1'b1, 8'd11, 1'b1});
        step(2); chk("t1_wb", {bus.dmem_we, bus.dmem_addr, bus.pc_ld, bus.pc_sel}, {1'b1, 8'd11, 1'b1, 1'b0});
        chk("t1_wdata", diff, 8'd2);
        step(1); chk("t1_next_fa", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'd3});
        chk("t1_mem", dp_mem[11], 8'd2);
        step(4);
        bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
        step(1); chk("t2_wb", bus.dmem_we, 1'b1);
        step(1); chk("t2_stopped", {bus.busy, dp_pc, dp_mem[13]}, {1'b0, 8'd6, 8'd8});

        // Self-branch halt at pc=6.
        pulse_start();
        chk("t3_fa", bus.rom_addr, 8'd6);
        step(6); chk("t3_wb_sel", bus.pc_sel, 1'b1);
        step(1); chk("t3_halt", {bus.halted, bus.busy, dp_pc, dp_mem[15]}, {1'b1, 1'b0, 8'd6, 8'hF9});
        pulse_start();
        step(2); chk("t3_start_ignored", {bus.halted, bus.busy, bus.rom_rd}, 3'b100);
        @(posedge clk); #1 rst = 1'b0;
        #2 chk("t3_reset", {bus.halted, bus.busy}, 2'b00);
        @(posedge clk); #1 rst = 1'b1;
        step(1); chk("t3_idle", {bus.halted, bus.busy}, 2'b00);

        // Branching instruction, then a zero result ended by stop in WB.
        rom[20] = 8'd16; rom[21] = 8'd17; rom[22] = 8'd40;
        poke(0, 10, 7); poke(0, 11, 5); poke(0, 16, 4); poke(0, 17, 4); poke(1, 0, 0);
        pulse_start();
        step(6);
        chk("t4_wb", {bus.pc_sel, bus.neg, bus.br_target, bus.dmem_addr}, {1'b1, 1'b1, 8'd20, 8'd11});
        chk("t4_wdata", diff, 8'hFE);
        step(1); chk("t4_target_fa", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'd20});
        chk("t4_mem", dp_mem[11], 8'hFE);
        step(6); chk("t5_wb", {bus.pc_sel, diff}, {1'b0, 8'd0});
        bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
        #1 chk("t5_done", {bus.busy, dp_pc, dp_mem[17]}, {1'b0, 8'd23, 8'd0});

        // PC wrap-around during fetch.
        rom[254] = 8'd1; rom[255] = 8'd2; rom[0] = 8'd3;
        poke(1, 0, 8'hFE);
        pulse_start();
        chk("t6_fa", bus.rom_addr, 8'hFE);
        step(1); chk("t6_fb", bus.rom_addr, 8'hFF);
        step(1); chk("t6_fc", bus.rom_addr, 8'h00);
        bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
        step(4); chk("t6_stopped", bus.busy, 1'b0);

        // Random programs with random start/stop pulses and occasional resets.
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) poke(0, 8'(i), 8'($urandom));
        poke(1, 0, 8'($urandom));
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 5) == 0);
            bus.stop  = ($urandom_range(0, 29) == 0);
            rst = !(($urandom_range(0, 299) == 0) || (bus.halted && $urandom_range(0, 3) == 0));
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b1;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
